// File: rtl/n8_pad_emulator.sv
// Device end of the N8 pad link: shifts live button bits out on latch/pulse strobes (N8_TURBO_EN adds A/B autofire).
// Latency: data_out follows a synchronised strobe edge by 1 clk, i.e. SYNC_STAGES+1 clk after the pin edge.
// Backpressure: none; the host paces the link and a new latch always restarts the frame.
module n8_pad_emulator #(
  parameter int   SYNC_STAGES     = 2,
  parameter logic TAIL_LEVEL      = 1'b0,
  parameter int   WATCHDOG_CYCLES = 50000,
  parameter int   TURBO_FRAMES    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       latch,
  input  logic       pulse,
  input  logic [7:0] buttons,
  output logic       data_out,
  output logic       busy,
  output logic       frame_done
);

  // Fewer than two stages would not be a synchroniser, so clamp.
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int WD_W = (WATCHDOG_CYCLES > 2) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  logic [1:0]      rst_sync;
  logic            rst_n;
  logic [SS-1:0]   latch_sync;
  logic [SS-1:0]   pulse_sync;
  logic            latch_d;
  logic            pulse_d;
  logic            latch_s;
  logic            pulse_s;
  logic            latch_r;
  logic            latch_f;
  logic            pulse_r;
  logic [7:0]      load_val;

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      shift_reg;
  logic [7:0]      shift_nxt;
  logic [2:0]      bit_cnt;
  logic [2:0]      bit_cnt_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_nxt;
  logic            data_nxt;
  logic            done_nxt;

  // Reset asserts immediately and releases synchronously to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Bring the host strobes into the clk domain and keep one extra copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_sync <= '0;
      pulse_sync <= '0;
      latch_d    <= 1'b0;
      pulse_d    <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SS-2:0], latch};
      pulse_sync <= {pulse_sync[SS-2:0], pulse};
      latch_d    <= latch_sync[SS-1];
      pulse_d    <= pulse_sync[SS-1];
    end
  end

  assign latch_s = latch_sync[SS-1];
  assign pulse_s = pulse_sync[SS-1];
  assign latch_r = latch_s & ~latch_d;
  assign latch_f = ~latch_s & latch_d;
  assign pulse_r = pulse_s & ~pulse_d;

`ifdef N8_TURBO_EN
  localparam int TF_W = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;
  localparam logic [TF_W-1:0] TF_LAST = TF_W'(TURBO_FRAMES - 1);

  logic [TF_W-1:0] frame_cnt;
  logic            turbo_tgl;

  // Count completed latches; flip the autofire phase every TURBO_FRAMES of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      turbo_tgl <= 1'b0;
    end else if (latch_f) begin
      if (frame_cnt == TF_LAST) begin
        frame_cnt <= '0;
        turbo_tgl <= ~turbo_tgl;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Held A/B only report pressed during the active autofire phase.
  assign load_val = {buttons[7:2], buttons[1:0] & {2{turbo_tgl}}};
`else
  logic unused_turbo_cfg;
  assign unused_turbo_cfg = ^TURBO_FRAMES;
  assign load_val = buttons;
`endif

  // State and datapath registers; data_out idles high (released) on the wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= 8'h00;
      bit_cnt    <= 3'd0;
      wd_cnt     <= '0;
      data_out   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      wd_cnt     <= wd_nxt;
      data_out   <= data_nxt;
      frame_done <= done_nxt;
    end
  end

  // Next state: a high latch overrides everything (including a coincident pulse edge).
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    bit_cnt_nxt = bit_cnt;
    wd_nxt      = wd_cnt;
    data_nxt    = data_out;
    done_nxt    = 1'b0;
    if (latch_r) wd_nxt = '0;
    if (latch_s) begin
      state_nxt   = LOAD;
      shift_nxt   = load_val;
      bit_cnt_nxt = 3'd0;
      data_nxt    = ~load_val[0];
    end else begin
      case (state)
        IDLE: data_nxt = 1'b1;
        LOAD: begin
          // Only reachable with latch low on its falling edge: freeze the frame here.
          shift_nxt   = load_val;
          bit_cnt_nxt = 3'd0;
          data_nxt    = ~load_val[0];
          if (latch_f) state_nxt = SHIFT;
        end
        SHIFT: begin
          if (wd_cnt == WD_LAST) begin
            state_nxt = IDLE;
            data_nxt  = 1'b1;
          end else begin
            wd_nxt = wd_cnt + 1'b1;
            if (pulse_r) begin
              shift_nxt   = {1'b0, shift_reg[7:1]};
              bit_cnt_nxt = bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state_nxt = DONE;
                done_nxt  = 1'b1;
                data_nxt  = TAIL_LEVEL;
              end else begin
                data_nxt = ~shift_reg[1];
              end
            end
          end
        end
        DONE: begin
          if (wd_cnt == WD_LAST) begin
            state_nxt = IDLE;
            data_nxt  = 1'b1;
          end else begin
            wd_nxt   = wd_cnt + 1'b1;
            data_nxt = TAIL_LEVEL;
          end
        end
        default: begin
          state_nxt = IDLE;
          data_nxt  = 1'b1;
        end
      endcase
    end
  end

  assign busy = (state == LOAD) || (state == SHIFT);

endmodule

// File: tb/tb_n8_pad_emulator.sv
// Bench for n8_pad_emulator: randomized host strobes against a frame-level model, scoreboard checking.
// Latency: expected wire bits are sampled by the monitor at each host pulse rising edge.
// Backpressure: none; strobes are held long enough for the synchronisers to settle.
`timescale 1ns/1ps
module tb_n8_pad_emulator;

  localparam int   SYNC = 2;
  localparam logic TAIL = 1'b0;
  localparam int   WD   = 200;
  localparam int   TF   = 4;
  localparam int   HOLD = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       latch = 1'b0;
  logic       pulse = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic       data_out;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  n8_pad_emulator #(
    .SYNC_STAGES(SYNC), .TAIL_LEVEL(TAIL), .WATCHDOG_CYCLES(WD), .TURBO_FRAMES(TF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .latch(latch), .pulse(pulse), .buttons(buttons),
    .data_out(data_out), .busy(busy), .frame_done(frame_done)
  );

  always #10 clk = ~clk;

  // Scoreboard queues
  logic  q_bit[$];
  int    q_done[$];
  string q_probe_n[$];
  logic  q_probe_d[$];
  logic  q_probe_b[$];
  event  probe_ev;

  // Frame-level reference model
  typedef enum int {M_IDLE, M_LATCHED, M_ACTIVE} mmode_t;
  mmode_t     m_mode = M_IDLE;
  logic [7:0] m_cur = 8'h00;
  logic [7:0] m_frame = 8'h00;
  int         m_pos = 0;
  int         m_falls = 0;

  function automatic logic [7:0] m_eff(input logic [7:0] b);
    logic [7:0] r;
    r = b;
`ifdef N8_TURBO_EN
    if (((m_falls / TF) % 2) == 0) r[1:0] = 2'b00;
`endif
    return r;
  endfunction

  function automatic logic m_wire();
    logic [7:0] t;
    if (m_mode == M_LATCHED) begin
      t = m_eff(m_cur);
      return ~t[0];
    end
    if (m_mode == M_ACTIVE) begin
      if (m_pos >= 8) return TAIL;
      t = m_frame >> m_pos;
      return ~t[0];
    end
    return 1'b1;
  endfunction

  function automatic logic m_busy();
    return (m_mode == M_LATCHED) || (m_mode == M_ACTIVE && m_pos < 8);
  endfunction

  // Stimulus tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic probe(input string n);
    q_probe_n.push_back(n);
    q_probe_d.push_back(m_wire());
    q_probe_b.push_back(m_busy());
    ->probe_ev;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_pos = 0;
    m_falls = 0;
  endtask

  task automatic do_reset();
    latch = 1'b0;
    pulse = 1'b0;
    reset_n = 1'b0;
    model_reset();
    cyc(3);
    reset_n = 1'b1;
    cyc(4);
  endtask

  task automatic latch_hi(input logic [7:0] b);
    buttons = b;
    m_cur = b;
    m_mode = M_LATCHED;
    latch = 1'b1;
    cyc(HOLD);
  endtask

  task automatic latch_lo();
    m_frame = m_eff(m_cur);
    m_falls++;
    m_pos = 0;
    m_mode = M_ACTIVE;
    latch = 1'b0;
    cyc(HOLD);
  endtask

  task automatic do_pulse();
    q_bit.push_back(m_wire());
    if (m_mode == M_ACTIVE && m_pos < 8) begin
      m_pos++;
      if (m_pos == 8) q_done.push_back(m_falls);
    end
    pulse = 1'b1;
    cyc(HOLD);
    pulse = 1'b0;
    cyc(HOLD);
  endtask

  // Latch and pulse rise together: the pulse must not shift anything.
  task automatic latch_with_pulse(input logic [7:0] b);
    q_bit.push_back(m_wire());
    buttons = b;
    m_cur = b;
    m_mode = M_LATCHED;
    latch = 1'b1;
    pulse = 1'b1;
    cyc(HOLD);
    pulse = 1'b0;
    cyc(HOLD);
  endtask

  // Monitor: wire bit as the host sees it at each pulse rising edge
  logic mon_exp;
  always @(posedge pulse) begin
    if (q_bit.size() == 0) begin
      errors++;
      $display("FAIL wire_bit: pulse with no expected bit queued, data_out=%b", data_out);
    end else begin
      mon_exp = q_bit.pop_front();
      checks++;
      if (data_out !== mon_exp) begin
        errors++;
        $display("FAIL wire_bit at %0t: data_out=%b expected %b", $time, data_out, mon_exp);
      end
    end
  end

  // Monitor: every frame_done pulse must match an expected completed frame
  int done_tok;
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      checks++;
      if (q_done.size() == 0) begin
        errors++;
        $display("FAIL frame_done at %0t: got pulse, expected none", $time);
      end else begin
        done_tok = q_done.pop_front();
      end
    end
  end

  // Monitor: static probes of data_out/busy
  string pn;
  logic  pd;
  logic  pb;
  always @(probe_ev) begin
    while (q_probe_n.size() > 0) begin
      pn = q_probe_n.pop_front();
      pd = q_probe_d.pop_front();
      pb = q_probe_b.pop_front();
      checks++;
      if (data_out !== pd || busy !== pb) begin
        errors++;
        $display("FAIL %s: data_out=%b busy=%b, expected data_out=%b busy=%b", pn, data_out, busy, pd, pb);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    int np;

    // Reset with no strobes
    do_reset();
    for (int i = 0; i < 100; i++) begin
      probe("reset_idle");
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_frame_done: got %b expected 0", frame_done);
      end
      checks++;
      cyc(1);
    end

    // A + Up frame, then tail bits
    latch_hi(8'b0001_0001);
    probe("load_state");
    latch_lo();
    probe("shift_state");
    for (int i = 0; i < 8; i++) do_pulse();
    probe("after_frame");
    for (int i = 0; i < 2; i++) do_pulse();

    // Abort after 3 bits, restart with Right only
    latch_hi(8'h3C);
    latch_lo();
    for (int i = 0; i < 3; i++) do_pulse();
    latch_hi(8'h80);
    probe("restart_load");
    latch_lo();
    for (int i = 0; i < 8; i++) do_pulse();

    // Latch and pulse in the same cycle
    latch_with_pulse(8'hA5);
    probe("latch_pulse_same");
    latch_lo();
    for (int i = 0; i < 8; i++) do_pulse();

    // Watchdog: no activity after latch falls
    latch_hi(8'hFF);
    latch_lo();
    cyc(WD + 10);
    m_mode = M_IDLE;
    probe("watchdog_idle");
    for (int i = 0; i < 10; i++) do_pulse();

    // Reset in the middle of a frame
    latch_hi(8'h0F);
    latch_lo();
    for (int i = 0; i < 3; i++) do_pulse();
    reset_n = 1'b0;
    model_reset();
    #1;
    probe("reset_mid_frame");
    cyc(3);
    reset_n = 1'b1;
    cyc(4);
    do_pulse();
    probe("after_reset_needs_latch");

    // A held across 16 frames (autofire pattern when turbo is built in)
    for (int f = 0; f < 16; f++) begin
      latch_hi(8'h01);
      latch_lo();
      do_pulse();
    end

    // Randomized frames; buttons wiggle during shifting
    for (int f = 0; f < 40; f++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) latch_with_pulse(b);
      else latch_hi(b);
      if ($urandom_range(0, 1) == 1) probe("rand_load");
      latch_lo();
      np = $urandom_range(0, 10);
      for (int p = 0; p < np; p++) begin
        buttons = 8'($urandom);
        do_pulse();
      end
      if ($urandom_range(0, 3) == 0) probe("rand_after");
    end

    cyc(10);
    checks++;
    if (q_done.size() != 0) begin
      errors++;
      $display("FAIL frame_done_missing: %0d pulses outstanding, expected 0", q_done.size());
    end
    checks++;
    if (q_bit.size() != 0) begin
      errors++;
      $display("FAIL wire_bits_pending: %0d outstanding, expected 0", q_bit.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
